bg_sequencer: RTL and testbench

Generates the 3-bit background index `bg` consumed by the background colour mux in the Simon display path.
- Steps `bg` forward or backward on player button presses.
- Optionally auto-advances `bg` every AUTO_FRAMES video frames (attract mode).
- After a button-driven change, ignores further presses for a short frame-based lockout.
- Raw button inputs are synchronised internally; `frame_tick` comes from the VGA timing block.

---
 rtl/bg_sequencer.sv | 108 ++++++++++
 tb/tb_bg_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bg_sequencer.sv
// Background index sequencer for the Simon display path: button stepping with
// frame-based lockout, plus optional frame-driven auto-advance.
module bg_sequencer #(
  parameter int INIT_BG        = 0,
  parameter int AUTO_FRAMES    = 120,
  parameter int LOCKOUT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  input  logic       frame_tick,
  output logic [2:0] bg,
  output logic       bg_changed,
  output logic       locked
);

  localparam int AW = ($clog2(AUTO_FRAMES + 1) < 1) ? 1 : $clog2(AUTO_FRAMES + 1);
  localparam int LW = ($clog2(LOCKOUT_FRAMES + 1) < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'((LOCKOUT_FRAMES > 0) ? LOCKOUT_FRAMES - 1 : 0);
  localparam logic [2:0]    INIT_VAL  = 3'(INIT_BG);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [AW-1:0] auto_cnt;
  logic [LW-1:0] lock_cnt;

  logic next_s1, next_s2, next_s2_d;
  logic prev_s1, prev_s2, prev_s2_d;
  logic next_edge, prev_edge;

  // Two-flop synchronisers plus a delay flop so a held button yields one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      next_s1   <= 1'b0;
      next_s2   <= 1'b0;
      next_s2_d <= 1'b0;
      prev_s1   <= 1'b0;
      prev_s2   <= 1'b0;
      prev_s2_d <= 1'b0;
    end else begin
      next_s1   <= btn_next;
      next_s2   <= next_s1;
      next_s2_d <= next_s2;
      prev_s1   <= btn_prev;
      prev_s2   <= prev_s1;
      prev_s2_d <= prev_s2;
    end
  end

  assign next_edge = next_s2 & ~next_s2_d;
  assign prev_edge = prev_s2 & ~prev_s2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bg         <= INIT_VAL;
      bg_changed <= 1'b0;
      locked     <= 1'b0;
      auto_cnt   <= '0;
      lock_cnt   <= '0;
    end else begin
      bg_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (next_edge ^ prev_edge) begin
            bg         <= next_edge ? bg + 3'd1 : bg - 3'd1;
            bg_changed <= 1'b1;
            auto_cnt   <= '0;
            if (LOCKOUT_FRAMES > 0) begin
              state  <= LOCK;
              locked <= 1'b1;
            end
          end else if (!next_edge && !prev_edge && auto_en && frame_tick) begin
            if (auto_cnt == AUTO_LAST) begin
              bg         <= bg + 3'd1;
              bg_changed <= 1'b1;
              auto_cnt   <= '0;
            end else begin
              auto_cnt <= auto_cnt + AW'(1);
            end
          end
        end
        LOCK: begin
          // Edges seen here, including on the exit cycle, are simply dropped
          if (frame_tick) begin
            if (lock_cnt == LOCK_LAST) begin
              lock_cnt <= '0;
              state    <= IDLE;
              locked   <= 1'b0;
            end else begin
              lock_cnt <= lock_cnt + LW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
      if (!auto_en) auto_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bg_sequencer.sv
// Self-checking bench for bg_sequencer: directed scenarios followed by random
// traffic, all compared each cycle against a frame-level behavioural model.
module tb_bg_sequencer;

  localparam int INIT_BG        = 0;
  localparam int AUTO_FRAMES    = 3;
  localparam int LOCKOUT_FRAMES = 8;

  logic       clk = 1'b0;
  logic       reset, btn_next, btn_prev, auto_en, frame_tick;
  logic [2:0] bg;
  logic       bg_changed, locked;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;

  // Reference model: button histories, index, frames left in lockout, ticks counted
  int m_bg, m_lock_left, m_auto;
  bit m_changed, m_locked;
  bit nh [0:3];
  bit ph [0:3];

  bg_sequencer #(
    .INIT_BG(INIT_BG), .AUTO_FRAMES(AUTO_FRAMES), .LOCKOUT_FRAMES(LOCKOUT_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_en(auto_en), .frame_tick(frame_tick),
    .bg(bg), .bg_changed(bg_changed), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    bit en, ep;
    for (int i = 3; i > 0; i--) begin
      nh[i] = nh[i-1];
      ph[i] = ph[i-1];
    end
    nh[0] = btn_next;
    ph[0] = btn_prev;
    en = nh[2] & ~nh[3];
    ep = ph[2] & ~ph[3];
    m_changed = 1'b0;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        nh[i] = 1'b0;
        ph[i] = 1'b0;
      end
      m_bg = INIT_BG; m_locked = 1'b0; m_lock_left = 0; m_auto = 0;
    end else begin
      if (!m_locked) begin
        if (en != ep) begin
          m_bg = en ? (m_bg + 1) % 8 : (m_bg + 7) % 8;
          m_changed = 1'b1;
          m_auto = 0;
          if (LOCKOUT_FRAMES > 0) begin
            m_locked = 1'b1;
            m_lock_left = LOCKOUT_FRAMES;
          end
        end else if (!en && !ep && auto_en && frame_tick) begin
          m_auto++;
          if (m_auto == AUTO_FRAMES) begin
            m_bg = (m_bg + 1) % 8;
            m_changed = 1'b1;
            m_auto = 0;
          end
        end
      end else if (frame_tick) begin
        m_lock_left--;
        if (m_lock_left == 0) m_locked = 1'b0;
      end
      if (!auto_en) m_auto = 0;
    end
  endtask

  task automatic applyStimulus(input logic nx, input logic pv, input logic ae,
                               input logic ft, input logic rs);
    @(negedge clk);
    btn_next = nx; btn_prev = pv; auto_en = ae; frame_tick = ft; reset = rs;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("bg", bg, m_bg);
    checkOutput("bg_changed", bg_changed, m_changed);
    checkOutput("locked", locked, m_locked);
    if (bg_changed) pulse_count++;
  endtask

  // Press a button for two cycles, then give the synchroniser time to land it
  task automatic pressButton(input logic nx, input logic pv, input logic ae);
    applyStimulus(nx, pv, ae, 1'b0, 1'b0);
    applyStimulus(nx, pv, ae, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, ae, 1'b0, 1'b0);
  endtask

  task automatic frameTicks(input int n, input logic ae);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, ae, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, ae, 1'b0, 1'b0);
    end
  endtask

  initial begin
    btn_next = 0; btn_prev = 0; auto_en = 0; frame_tick = 0; reset = 1;
    for (int i = 0; i < 4; i++) begin
      nh[i] = 0;
      ph[i] = 0;
    end
    m_bg = INIT_BG; m_locked = 0; m_lock_left = 0; m_auto = 0; m_changed = 0;

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset_bg", bg, INIT_BG);
    checkOutput("reset_locked", locked, 0);

    // Eight forward steps wrap back to the start; check the two-edge latency
    pulse_count = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t1_lat_n", bg_changed, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t1_lat_n1", bg_changed, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t1_lat_n2", bg_changed, 1);
      checkOutput("t1_step", bg, (k + 1) % 8);
      frameTicks(LOCKOUT_FRAMES + 2, 0);
    end
    checkOutput("t1_pulses", pulse_count, 8);
    checkOutput("t1_wrap", bg, 0);

    // Backward wrap and lockout duration
    applyStimulus(0, 0, 0, 0, 1);
    pressButton(0, 1, 0);
    checkOutput("t2_bg", bg, 7);
    checkOutput("t2_locked", locked, 1);
    frameTicks(LOCKOUT_FRAMES - 1, 0);
    checkOutput("t2_still_locked", locked, 1);
    frameTicks(1, 0);
    checkOutput("t2_unlocked", locked, 0);

    // Second press during lockout is discarded
    pressButton(1, 0, 0);
    frameTicks(3, 0);
    pressButton(1, 0, 0);
    checkOutput("t3_once", bg, 0);
    frameTicks(LOCKOUT_FRAMES - 3, 0);
    checkOutput("t3_unlocked", locked, 0);
    pressButton(1, 0, 0);
    checkOutput("t3_again", bg, 1);
    frameTicks(LOCKOUT_FRAMES, 0);

    // Simultaneous presses cancel
    pulse_count = 0;
    pressButton(1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_bg", bg, 1);
    checkOutput("t4_locked", locked, 0);
    checkOutput("t4_pulses", pulse_count, 0);

    // Auto-advance every third tick, never locking
    frameTicks(9, 1);
    checkOutput("t5_bg", bg, 4);
    checkOutput("t5_locked", locked, 0);
    frameTicks(2, 1);
    applyStimulus(0, 0, 0, 0, 0);
    frameTicks(2, 1);
    checkOutput("t5_restart", bg, 4);
    frameTicks(1, 1);
    checkOutput("t5_fresh", bg, 5);

    // Reset during lockout
    pressButton(1, 0, 0);
    checkOutput("t6_locked", locked, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_bg", bg, INIT_BG);
    checkOutput("t6_locked0", locked, 0);
    checkOutput("t6_changed", bg_changed, 0);
    pressButton(1, 0, 0);
    checkOutput("t6_accept", bg, (INIT_BG + 1) % 8);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic nx, pv, ae, ft, rs;
      nx = btn_next; pv = btn_prev; ae = auto_en;
      if ($urandom_range(0, 9) == 0) nx = ~nx;
      if ($urandom_range(0, 11) == 0) pv = ~pv;
      if ($urandom_range(0, 149) == 0) ae = ~ae;
      ft = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 299) == 0);
      applyStimulus(nx, pv, ae, ft, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
